// File: rtl/bsg_fma_mul_issue_if.sv
// Request, multiplier-side and result channels of the bsg_fma_mul_issue stage.
// Signal names are kept relative to the issue stage so the port list reads like the block's own.
interface bsg_fma_mul_issue_if #(
    parameter int width_p     = 32,
    parameter int tag_width_p = 4
);
    logic                   v_i;
    logic                   ready_o;
    logic [width_p-1:0]     opA_i;
    logic [width_p-1:0]     opB_i;
    logic [1:0]             op_i;
    logic [tag_width_p-1:0] tag_i;

    logic                   mul_v_o;
    logic                   mul_ready_i;
    logic [width_p-1:0]     mul_opA_o;
    logic [width_p-1:0]     mul_opB_o;
    logic                   mul_signed_o;
    logic                   mul_high_o;
    logic                   mul_v_i;
    logic [width_p-1:0]     mul_res_i;

    logic                   v_o;
    logic [width_p-1:0]     data_o;
    logic [tag_width_p-1:0] tag_o;
    logic                   yumi_i;

    modport slave (
        input  v_i, opA_i, opB_i, op_i, tag_i, mul_ready_i, mul_v_i, mul_res_i, yumi_i,
        output ready_o, mul_v_o, mul_opA_o, mul_opB_o, mul_signed_o, mul_high_o,
               v_o, data_o, tag_o
    );

    modport master (
        output v_i, opA_i, opB_i, op_i, tag_i, mul_ready_i, mul_v_i, mul_res_i, yumi_i,
        input  ready_o, mul_v_o, mul_opA_o, mul_opB_o, mul_signed_o, mul_high_o,
               v_o, data_o, tag_o
    );
endinterface

// File: rtl/bsg_fma_mul_issue.sv
// Issue/retire stage for an untagged, unbackpressured 32-bit multiplier: queues requests,
// tracks tags of in-flight ops and buffers results in a credit-protected output FIFO.
module bsg_fma_mul_issue #(
    parameter int width_p     = 32,
    parameter int tag_width_p = 4,
    parameter int els_p       = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    bsg_fma_mul_issue_if.slave io
);
    localparam int ptr_w_lp = $clog2(els_p);
    localparam int cnt_w_lp = ptr_w_lp + 1;
    localparam logic [cnt_w_lp:0]   els_sum_lp = (cnt_w_lp + 1)'(els_p);
    localparam logic [cnt_w_lp-1:0] els_cnt_lp = cnt_w_lp'(els_p);

    typedef enum logic [1:0] {
        OP_MUL   = 2'd0,
        OP_MULH  = 2'd1,
        OP_MULHU = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef struct packed {
        logic [width_p-1:0]     a;
        logic [width_p-1:0]     b;
        logic [1:0]             op;
        logic [tag_width_p-1:0] tag;
    } req_s;

    typedef struct packed {
        logic [width_p-1:0]     data;
        logic [tag_width_p-1:0] tag;
    } res_s;

    req_s                   in_mem  [2];
    logic [tag_width_p-1:0] tag_mem [els_p];
    res_s                   out_mem [els_p];

    logic                in_wr_q,  in_wr_d,  in_rd_q,  in_rd_d;
    logic [1:0]          in_cnt_q, in_cnt_d;
    logic [ptr_w_lp-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [ptr_w_lp-1:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;
    logic [cnt_w_lp-1:0] inflight_q, inflight_d, out_cnt_q, out_cnt_d;
    logic                hi_busy_q, hi_busy_d;

    req_s              in_head;
    logic              head_high;
    logic              accept, issue, retire, consume;
    logic [cnt_w_lp:0] used;

    assign in_head   = in_mem[in_rd_q];
    assign head_high = (in_head.op == OP_MULH) || (in_head.op == OP_MULHU);
    assign used      = {1'b0, inflight_q} + {1'b0, out_cnt_q};

    assign accept  = io.v_i & io.ready_o;
    assign issue   = (in_cnt_q != 2'd0) & io.mul_ready_i & (used < els_sum_lp) & ~hi_busy_q;
    assign retire  = io.mul_v_i & (inflight_q != '0);
    assign consume = io.yumi_i & (out_cnt_q != '0);

    assign io.ready_o      = (in_cnt_q != 2'd2);
    assign io.mul_v_o      = issue;
    assign io.mul_opA_o    = in_head.a;
    assign io.mul_opB_o    = in_head.b;
    assign io.mul_signed_o = (in_head.op == OP_MULH);
    assign io.mul_high_o   = head_high;
    assign io.v_o          = (out_cnt_q != '0);
    assign io.data_o       = out_mem[out_rd_q].data;
    assign io.tag_o        = out_mem[out_rd_q].tag;

    assign in_wr_d    = in_wr_q ^ accept;
    assign in_rd_d    = in_rd_q ^ issue;
    assign in_cnt_d   = in_cnt_q + 2'(accept) - 2'(issue);
    assign tag_wr_d   = tag_wr_q + ptr_w_lp'(issue);
    assign tag_rd_d   = tag_rd_q + ptr_w_lp'(retire);
    assign out_wr_d   = out_wr_q + ptr_w_lp'(retire);
    assign out_rd_d   = out_rd_q + ptr_w_lp'(consume);
    assign inflight_d = inflight_q + cnt_w_lp'(issue) - cnt_w_lp'(retire);
    assign out_cnt_d  = out_cnt_q + cnt_w_lp'(retire) - cnt_w_lp'(consume);

    // The high op is always the youngest in flight, so its result is the one that
    // retires with a single op outstanding; older low results must not release the block.
    always_comb begin
        hi_busy_d = hi_busy_q;
        if (issue && head_high) begin
            hi_busy_d = 1'b1;
        end else if (retire && inflight_q == cnt_w_lp'(1)) begin
            hi_busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            in_wr_q    <= 1'b0;
            in_rd_q    <= 1'b0;
            in_cnt_q   <= 2'd0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            out_wr_q   <= '0;
            out_rd_q   <= '0;
            inflight_q <= '0;
            out_cnt_q  <= '0;
            hi_busy_q  <= 1'b0;
        end else begin
            in_wr_q    <= in_wr_d;
            in_rd_q    <= in_rd_d;
            in_cnt_q   <= in_cnt_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            out_wr_q   <= out_wr_d;
            out_rd_q   <= out_rd_d;
            inflight_q <= inflight_d;
            out_cnt_q  <= out_cnt_d;
            hi_busy_q  <= hi_busy_d;
        end
    end

    // NOTE: FIFO storage is deliberately left unreset; the counters and pointers alone
    // decide which entries are live, so clearing the arrays would only cost flops.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            in_mem[in_wr_q] <= '{a: io.opA_i, b: io.opB_i, op: io.op_i, tag: io.tag_i};
        end
        if (issue) begin
            tag_mem[tag_wr_q] <= in_head.tag;
        end
        if (retire) begin
            out_mem[out_wr_q] <= '{data: io.mul_res_i, tag: tag_mem[tag_rd_q]};
        end
    end

    mul_overflow_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(io.mul_v_i && out_cnt_q == els_cnt_lp));

endmodule

// File: tb/tb_bsg_fma_mul_issue.sv
// Scoreboard bench for bsg_fma_mul_issue with a behavioural multiplier (fixed latencies,
// optional ready hold-off). Inputs change 1ns after posedge; outputs are sampled at negedge.
module tb_bsg_fma_mul_issue;
    localparam int width_lp = 32;
    localparam int tag_w_lp = 4;
    localparam int els_lp   = 4;

    logic clk_i = 1'b0;
    logic reset_n_i;
    always #5 clk_i = ~clk_i;

    bsg_fma_mul_issue_if #(.width_p(width_lp), .tag_width_p(tag_w_lp)) bus ();

    bsg_fma_mul_issue #(.width_p(width_lp), .tag_width_p(tag_w_lp), .els_p(els_lp)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .io        (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
    } exp_s;

    typedef struct {
        logic [31:0] res;
        int          due;
        logic        hi;
    } pipe_s;

    exp_s  sb_q[$];
    pipe_s pipe_q[$];
    exp_s  mon_e;

    int checks = 0, errors = 0;
    int issues = 0, high_issues = 0, signed_issues = 0, outs_seen = 0;
    int cyc = 0, lat_lo = 2, lat_hi = 4, hold_cnt = 0;
    bit hold_en = 0, hi_out = 0, ret_hi = 0, yumi_en = 1, bp_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic hi, input logic sg);
        logic [63:0] p;
        if (sg) p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        else    p = {32'd0, a} * {32'd0, b};
        return hi ? p[63:32] : p[31:0];
    endfunction

    // Multiplier model: capture issues at negedge, return results after a fixed latency.
    always @(negedge clk_i) begin
        if (bus.mul_v_o) begin
            check("no_issue_behind_high", 64'(hi_out), 64'd0);
            issues++;
            if (bus.mul_high_o)   high_issues++;
            if (bus.mul_signed_o) signed_issues++;
            pipe_q.push_back('{res: mul_model(bus.mul_opA_o, bus.mul_opB_o, bus.mul_high_o, bus.mul_signed_o),
                               due: cyc + (bus.mul_high_o ? lat_hi : lat_lo),
                               hi:  bus.mul_high_o});
            if (bus.mul_high_o) begin
                hi_out = 1'b1;
                if (hold_en) hold_cnt = 5;
            end
        end
        if (bus.mul_v_i && ret_hi) hi_out = 1'b0;
    end

    always @(posedge clk_i) begin
        #1;
        cyc++;
        bus.mul_ready_i = (hold_cnt == 0);
        if (hold_cnt > 0) hold_cnt--;
        if (pipe_q.size() > 0 && pipe_q[0].due <= cyc) begin
            bus.mul_v_i   = 1'b1;
            bus.mul_res_i = pipe_q[0].res;
            ret_hi        = pipe_q[0].hi;
            void'(pipe_q.pop_front());
        end else begin
            bus.mul_v_i = 1'b0;
            ret_hi      = 1'b0;
        end
        bus.yumi_i = yumi_en & bus.v_o;
    end

    // Monitor: every consumed result must match the oldest expected entry.
    always @(negedge clk_i) begin
        if (bus.v_o && bus.yumi_i) begin
            outs_seen++;
            if (sb_q.size() == 0) begin
                check("unexpected_output", 64'(bus.tag_o), 64'hFFFF);
            end else begin
                mon_e = sb_q.pop_front();
                check("result_data", 64'(bus.data_o), 64'(mon_e.data));
                check("result_tag",  64'(bus.tag_o),  64'(mon_e.tag));
            end
        end
    end

    // Called and returns 1ns after a posedge.
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, input logic [31:0] exp_res);
        int waited = 0;
        bus.v_i = 1'b1; bus.op_i = op; bus.opA_i = a; bus.opB_i = b; bus.tag_i = tag;
        @(negedge clk_i);
        while (!bus.ready_o && waited < 200) begin
            @(negedge clk_i);
            waited++;
        end
        if (!bus.ready_o) check("send_timeout", 64'(bus.ready_o), 64'd1);
        else              sb_q.push_back('{data: exp_res, tag: tag});
        @(posedge clk_i); #1;
        bus.v_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(posedge clk_i);
            n++;
        end
        #1;
        check("drain_pending", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bus.v_i = 1'b0; bus.op_i = 2'd0; bus.opA_i = '0; bus.opB_i = '0; bus.tag_i = '0;
        bus.mul_ready_i = 1'b1; bus.mul_v_i = 1'b0; bus.mul_res_i = '0; bus.yumi_i = 1'b0;
        reset_n_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_ready", 64'(bus.ready_o), 64'd1);
        check("reset_v_o",   64'(bus.v_o),     64'd0);
        check("reset_mul_v", 64'(bus.mul_v_o), 64'd0);
        reset_n_i = 1'b1;
        idle(1);

        // Single MUL
        send(2'd0, 32'h3, 32'h5, 4'd1, 32'h0000_000F);
        wait_drain();
        check("mul_issue_count", 64'(issues), 64'd1);
        check("mul_high_count",  64'(high_issues), 64'd0);

        // MULH with a MUL queued behind it
        send(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 32'h0000_0000);
        send(2'd0, 32'h3, 32'h5, 4'd3, 32'h0000_000F);
        wait_drain();
        check("mulh_high_count",   64'(high_issues),   64'd1);
        check("mulh_signed_count", 64'(signed_issues), 64'd1);

        // MULHU
        send(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd4, 32'hFFFF_FFFE);
        wait_drain();
        check("mulhu_high_count",   64'(high_issues),   64'd2);
        check("mulhu_signed_count", 64'(signed_issues), 64'd1);

        // Back-pressure: 8 requests, output held
        yumi_en = 1'b0;
        base = issues;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(2'd0, 32'(i + 1), 32'd2, 4'(i), 32'(2 * (i + 1)));
                bp_done = 1'b1;
            end
        join_none
        idle(30);
        @(negedge clk_i);
        check("bp_issue_count", 64'(issues - base), 64'd4);
        check("bp_mul_v_idle",  64'(bus.mul_v_o),   64'd0);
        check("bp_ready_low",   64'(bus.ready_o),   64'd0);
        check("bp_v_o",         64'(bus.v_o),       64'd1);
        @(posedge clk_i); #1;
        yumi_en = 1'b1;
        for (int n = 0; n < 300 && !bp_done; n++) @(posedge clk_i);
        #1;
        check("bp_sender_done", 64'(bp_done), 64'd1);
        wait_drain();
        check("bp_issue_total", 64'(issues - base), 64'd8);

        // Mixed stream with ready held low after the high op
        hold_en = 1'b1;
        send(2'd0, 32'd2, 32'd3, 4'd0, 32'd6);
        send(2'd2, 32'h8000_0000, 32'd4, 4'd1, 32'd2);
        send(2'd0, 32'h10, 32'h10, 4'd2, 32'h100);
        wait_drain();
        hold_en = 1'b0;

        // Async reset with 2 in flight and 1 buffered
        yumi_en = 1'b0;
        lat_lo  = 12;
        send(2'd0, 32'd7, 32'd7, 4'd5, 32'd49);
        for (int n = 0; n < 50 && !bus.v_o; n++) @(posedge clk_i);
        #1;
        check("rst_buffered", 64'(bus.v_o), 64'd1);
        base = issues;
        send(2'd0, 32'd1, 32'd1, 4'd6, 32'd1);
        send(2'd0, 32'd2, 32'd2, 4'd7, 32'd4);
        idle(3);
        check("rst_two_inflight", 64'(issues - base), 64'd2);
        @(negedge clk_i);
        reset_n_i = 1'b0;
        #1;
        check("rst_v_o",   64'(bus.v_o),     64'd0);
        check("rst_ready", 64'(bus.ready_o), 64'd1);
        check("rst_mul_v", 64'(bus.mul_v_o), 64'd0);
        sb_q.delete();
        base = outs_seen;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        lat_lo  = 2;
        yumi_en = 1'b1;
        idle(20);
        check("rst_late_pipe_empty", 64'(pipe_q.size()), 64'd0);
        check("rst_no_output",       64'(outs_seen - base), 64'd0);
        check("rst_v_o_after",       64'(bus.v_o), 64'd0);
        send(2'd0, 32'd7, 32'd6, 4'd9, 32'd42);
        wait_drain();
        check("rst_next_completes", 64'(outs_seen - base), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
